// File: rtl/l2_plru_array_if.sv
// rtl/l2_plru_array_if.sv - request/response bundle between the L2 pipeline and the PLRU array (flush port under PLRU_FLUSH_EN)
interface l2_plru_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);

    logic             ready;
    logic             update_valid;
    logic [SET_W-1:0] update_set;
    logic [WAY_W-1:0] update_way;
    logic             lookup_valid;
    logic [SET_W-1:0] lookup_set;
    logic             victim_valid;
    logic [WAY_W-1:0] victim_way;
`ifdef PLRU_FLUSH_EN
    logic             flush;

    modport master (
        input  ready, victim_valid, victim_way,
        output update_valid, update_set, update_way, lookup_valid, lookup_set, flush
    );
    modport slave (
        output ready, victim_valid, victim_way,
        input  update_valid, update_set, update_way, lookup_valid, lookup_set, flush
    );
`else
    modport master (
        input  ready, victim_valid, victim_way,
        output update_valid, update_set, update_way, lookup_valid, lookup_set
    );
    modport slave (
        output ready, victim_valid, victim_way,
        input  update_valid, update_set, update_way, lookup_valid, lookup_set
    );
`endif
endinterface

// File: rtl/l2_plru_array.sv
// rtl/l2_plru_array.sv - per-set tree pseudo-LRU store with init sweep and same-cycle forwarding (optional PLRU_FLUSH_EN)
module l2_plru_array #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8
) (
    input  logic   clk,
    input  logic   rst,
    l2_plru_if.slave bus
);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int SET_W  = $clog2(NUM_SETS);
    localparam int TREE_W = NUM_WAYS - 1;
    localparam logic [SET_W-1:0] SWEEP_LAST = SET_W'(NUM_SETS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q;
    logic [SET_W-1:0]  sweep_q;
    logic              ready_q;
    logic              victim_valid_q;
    logic [WAY_W-1:0]  victim_way_q;
    logic [TREE_W-1:0] tree_q [NUM_SETS];

    logic              flush_req;
    logic              run_ok;
    logic              upd_en;
    logic [TREE_W-1:0] update_tree;
    logic [TREE_W-1:0] lookup_tree;

    // Walk root to leaf, recording the direction taken at each node on the path.
    function automatic logic [TREE_W-1:0] plru_update(input logic [TREE_W-1:0] bits,
                                                      input logic [WAY_W-1:0]  way);
        logic [TREE_W-1:0] res;
        int node;
        int dir;
        res  = bits;
        node = 0;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            dir = (int'(way) >> l) & 1;
            for (int n = 0; n < TREE_W; n++) begin
                if (n == node) res[n] = dir[0];
            end
            node = 2 * node + 1 + dir;
        end
        return res;
    endfunction

    // Walk root to leaf against each node bit; the leaf reached is the victim.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] bits);
        int   node;
        logic b;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < TREE_W; n++) begin
                if (n == node) b = bits[n];
            end
            node = 2 * node + 1 + (b ? 0 : 1);
        end
        return WAY_W'(node - (NUM_WAYS - 1));
    endfunction

`ifdef PLRU_FLUSH_EN
    assign flush_req = bus.flush;
`else
    assign flush_req = 1'b0;
`endif

    // A flush cycle swallows any update or lookup presented with it.
    assign run_ok      = (state_q == ST_RUN) && !flush_req;
    assign upd_en      = run_ok && bus.update_valid;
    assign update_tree = plru_update(tree_q[bus.update_set], bus.update_way);

    // Forward a same-set update so the victim reflects the access just made.
    always_comb begin
        lookup_tree = tree_q[bus.lookup_set];
        if (upd_en && (bus.update_set == bus.lookup_set)) begin
            lookup_tree = plru_update(tree_q[bus.lookup_set], bus.update_way);
        end
    end

    // Control FSM: init sweep sequencing, ready and registered victim response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_INIT;
            sweep_q        <= '0;
            ready_q        <= 1'b0;
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    victim_valid_q <= 1'b0;
                    sweep_q        <= sweep_q + 1'b1;
                    if (sweep_q == SWEEP_LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    if (flush_req) begin
                        state_q        <= ST_INIT;
                        sweep_q        <= '0;
                        ready_q        <= 1'b0;
                        victim_valid_q <= 1'b0;
                    end else begin
                        victim_valid_q <= bus.lookup_valid;
                        if (bus.lookup_valid) begin
                            victim_way_q <= plru_victim(lookup_tree);
                        end
                    end
                end
            endcase
        end
    end

    // Tree storage: cleared one set per cycle while sweeping, otherwise takes updates.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            tree_q[sweep_q] <= '0;
        end else if (upd_en) begin
            tree_q[bus.update_set] <= update_tree;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.victim_valid = victim_valid_q;
    assign bus.victim_way   = victim_way_q;

endmodule

// File: tb/tb_l2_plru_array.sv
// tb/tb_l2_plru_array.sv - randomized and directed check of l2_plru_array against a recency model
module tb_l2_plru_array;
    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 8;
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int WAY_W    = $clog2(NUM_WAYS);

    logic clk;
    logic rst;

    l2_plru_if #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) bus ();

    l2_plru_array #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Model: per set, the time each way was last touched (-1 = never since clear).
    int stamp [NUM_SETS][NUM_WAYS];
    int tick;
    int m_init_left;
    bit exp_valid;
    int exp_way;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++)
                stamp[s][w] = -1;
    endfunction

    function automatic void model_touch(input int s, input int w);
        tick++;
        stamp[s][w] = tick;
    endfunction

    // Halve the way range repeatedly, moving away from the half touched most recently.
    function automatic int model_victim(input int s);
        int lo, hi, mid, lm, rm;
        lo = 0;
        hi = NUM_WAYS;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            lm = -1;
            rm = -1;
            for (int w = lo; w < mid; w++) if (stamp[s][w] > lm) lm = stamp[s][w];
            for (int w = mid; w < hi; w++) if (stamp[s][w] > rm) rm = stamp[s][w];
            if (rm > lm) hi = mid;
            else lo = mid;
        end
        return lo;
    endfunction

    task automatic cycle(input bit uv, input int us, input int uw, input bit lv, input int ls,
                         input bit fl, input string tag);
        bit acc;
        bit fl_eff;
        bus.update_valid = uv;
        bus.update_set   = us[SET_W-1:0];
        bus.update_way   = uw[WAY_W-1:0];
        bus.lookup_valid = lv;
        bus.lookup_set   = ls[SET_W-1:0];
        fl_eff = 1'b0;
`ifdef PLRU_FLUSH_EN
        bus.flush = fl;
        fl_eff    = fl;
`endif
        acc = !rst && (m_init_left == 0);
        exp_valid = 1'b0;
        if (acc && fl_eff) begin
            model_clear();
            m_init_left = NUM_SETS + 1;
        end else begin
            if (acc && uv) model_touch(us, uw);
            exp_valid = acc && lv;
            if (exp_valid) exp_way = model_victim(ls);
        end
        @(posedge clk);
        #1;
        if (rst) m_init_left = NUM_SETS;
        else if (m_init_left > 0) m_init_left--;
        chk({tag, ".ready"}, {31'b0, bus.ready}, {31'b0, m_init_left == 0});
        chk({tag, ".vvalid"}, {31'b0, bus.victim_valid}, {31'b0, exp_valid});
        chk({tag, ".vway"}, {30'b0, bus.victim_way}, exp_way);
        if (exp_valid && uv && (us == ls))
            chk({tag, ".not_upd_way"}, {31'b0, int'(bus.victim_way) != uw}, 32'd1);
        bus.update_valid = 1'b0;
        bus.lookup_valid = 1'b0;
`ifdef PLRU_FLUSH_EN
        bus.flush = 1'b0;
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        tick        = 0;
        exp_way     = 0;
        exp_valid   = 1'b0;
        m_init_left = NUM_SETS;
        model_clear();
        rst = 1'b1;
        bus.update_valid = 1'b0;
        bus.update_set   = '0;
        bus.update_way   = '0;
        bus.lookup_valid = 1'b0;
        bus.lookup_set   = '0;
`ifdef PLRU_FLUSH_EN
        bus.flush = 1'b0;
`endif

        // Reset state, requests during reset ignored.
        cycle(1, 1, 2, 1, 1, 0, "rst0");
        cycle(0, 0, 0, 1, 5, 0, "rst1");
        @(negedge clk);
        rst = 1'b0;

        // Init sweep: requests every cycle are ignored, ready after exactly NUM_SETS cycles.
        for (int i = 0; i < NUM_SETS; i++)
            cycle(1, $urandom_range(0, NUM_SETS - 1), $urandom_range(0, NUM_WAYS - 1),
                  1, $urandom_range(0, NUM_SETS - 1), 0, $sformatf("init%0d", i));

        cycle(0, 0, 0, 1, 5, 0, "set5");
        chk("set5_lit", {30'b0, bus.victim_way}, 32'd3);
        for (int s = 0; s < NUM_SETS; s++) cycle(0, 0, 0, 1, s, 0, $sformatf("clean%0d", s));

        // Directed set 2 sequence.
        for (int w = 0; w < NUM_WAYS; w++) cycle(1, 2, w, 0, 0, 0, $sformatf("s2u%0d", w));
        cycle(0, 0, 0, 1, 2, 0, "s2a");
        chk("s2a_lit", {30'b0, bus.victim_way}, 32'd0);
        cycle(1, 2, 0, 0, 0, 0, "s2u0b");
        cycle(0, 0, 0, 1, 2, 0, "s2b");
        chk("s2b_lit", {30'b0, bus.victim_way}, 32'd2);

        // Same-cycle collision and independent different-set pair.
        cycle(1, 4, 3, 1, 4, 0, "col44");
        chk("col44_lit", {30'b0, bus.victim_way}, 32'd1);
        cycle(1, 4, 3, 1, 6, 0, "col46");
        chk("col46_lit", {30'b0, bus.victim_way}, 32'd3);

        // Randomized mixed traffic, biased toward collisions.
        for (int i = 0; i < 300; i++) begin
            int us, ls;
            us = $urandom_range(0, NUM_SETS - 1);
            ls = ($urandom_range(0, 2) == 0) ? us : $urandom_range(0, NUM_SETS - 1);
            cycle($urandom_range(0, 1), us, $urandom_range(0, NUM_WAYS - 1),
                  $urandom_range(0, 1), ls, 0, $sformatf("rnd%0d", i));
        end

        // Reset pulse with a lookup result in flight.
        cycle(1, 3, 1, 1, 3, 0, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_vvalid", {31'b0, bus.victim_valid}, 32'd0);
        chk("rst_async_ready", {31'b0, bus.ready}, 32'd0);
        model_clear();
        exp_way = 0;
        cycle(1, 3, 1, 1, 3, 0, "rst_hold");
        rst = 1'b0;
        for (int i = 0; i < NUM_SETS; i++)
            cycle(1, $urandom_range(0, NUM_SETS - 1), 0, 1, $urandom_range(0, NUM_SETS - 1),
                  0, $sformatf("resweep%0d", i));
        for (int s = 0; s < NUM_SETS; s++) cycle(0, 0, 0, 1, s, 0, $sformatf("postrst%0d", s));

`ifdef PLRU_FLUSH_EN
        for (int i = 0; i < 20; i++)
            cycle(1, $urandom_range(0, NUM_SETS - 1), $urandom_range(0, NUM_WAYS - 1),
                  0, 0, 0, $sformatf("prefl%0d", i));
        cycle(1, 1, 0, 1, 1, 1, "flush");
        for (int i = 0; i < NUM_SETS; i++)
            cycle(1, 1, 0, 1, 1, (i == 2), $sformatf("flinit%0d", i));
        for (int s = 0; s < NUM_SETS; s++) cycle(0, 0, 0, 1, s, 0, $sformatf("postfl%0d", s));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
